// File: rtl/bpfcap_pkg.sv
// Shared bpfcap types and timestamp constants.
package bpfcap_pkg;

  typedef struct packed {
    logic [31:0] seconds;
    logic [31:0] nanoseconds;
  } ts_t;

  localparam int unsigned NS_PER_TICK = 20;
  localparam int unsigned NS_WRAP     = 1_000_000_000;

endpackage

// File: rtl/ts_snapshot_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr+1 mod N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = |req;
    // Walk from farthest to nearest so the port right after ptr wins last.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant_onehot      = '0;
        grant_onehot[idx] = 1'b1;
        grant_idx         = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ts_snapshot_arb.sv
// Per-port timestamp snapshot slots, serialized round-robin onto one stream.
// Optional macro TS_SNAPSHOT_DROP_CNT_EN enables the saturating drop counter.
module ts_snapshot_arb
  import bpfcap_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DROP_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                ts_seconds,
  input  logic [31:0]                ts_nanoseconds,
  input  logic [NUM_REQ-1:0]         sof_pulse,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic [31:0]                out_seconds,
  output logic [31:0]                out_nanoseconds,
  output logic [NUM_REQ-1:0]         pending,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_nxt;
  logic [IW-1:0]      ptr_q;
  ts_t                slot_p0 [NUM_REQ];
  logic [NUM_REQ-1:0] pend_p0;
  ts_t                out_ts_p1;
  logic [IW-1:0]      out_id_p1;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic               load;
  logic [NUM_REQ-1:0] drain;
  ts_t                ts_now;

  assign ts_now = '{seconds: ts_seconds, nanoseconds: ts_nanoseconds};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req          (pend_p0),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (grant_any) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (grant_any) load = 1'b1;
          else           state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    drain = load ? grant_onehot : '0;
  end

  // Stage p0: capture into per-port slots; a slot drained this cycle may refill.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_p0 <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot_p0[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sof_pulse[i] && (!pend_p0[i] || drain[i])) slot_p0[i] <= ts_now;
      end
      pend_p0 <= sof_pulse | (pend_p0 & ~drain);
    end
  end

  // Stage p1: output register, loaded only on a grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      ptr_q     <= IW'(NUM_REQ - 1);
      out_ts_p1 <= '0;
      out_id_p1 <= '0;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        out_ts_p1 <= slot_p0[grant_idx];
        out_id_p1 <= grant_idx;
        ptr_q     <= grant_idx;
      end
    end
  end

  assign out_valid       = (state_q == FULL);
  assign out_id          = out_id_p1;
  assign out_seconds     = out_ts_p1.seconds;
  assign out_nanoseconds = out_ts_p1.nanoseconds;
  assign pending         = pend_p0;

`ifdef TS_SNAPSHOT_DROP_CNT_EN
  logic [NUM_REQ-1:0] drop_vec;
  logic [DROP_W-1:0]  drop_q;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [NUM_REQ-1:0] v);
    logic [DROP_W:0] sum;
    sum = {1'b0, a};
    for (int i = 0; i < NUM_REQ; i++) sum = sum + (DROP_W+1)'(v[i]);
    return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  endfunction

  assign drop_vec = sof_pulse & pend_p0 & ~drain;

  always_ff @(posedge clk) begin
    if (!reset_n) drop_q <= '0;
    else          drop_q <= sat_add(drop_q, drop_vec);
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_ts_snapshot_arb.sv
// Scoreboard bench for ts_snapshot_arb (NUM_REQ=4, DROP_W=16).
module tb_ts_snapshot_arb;

  localparam int NUM_REQ = 4;
  localparam int DROP_W  = 16;
  localparam int IW      = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   s;
    logic [31:0]   ns;
  } exp_t;

  logic               clk;
  logic               reset_n;
  logic [31:0]        ts_seconds;
  logic [31:0]        ts_nanoseconds;
  logic [NUM_REQ-1:0] sof_pulse;
  logic               out_valid;
  logic               out_ready;
  logic [IW-1:0]      out_id;
  logic [31:0]        out_seconds;
  logic [31:0]        out_nanoseconds;
  logic [NUM_REQ-1:0] pending;
  logic [DROP_W-1:0]  drop_count;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ts_snapshot_arb #(.NUM_REQ(NUM_REQ), .DROP_W(DROP_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ts_seconds      (ts_seconds),
    .ts_nanoseconds  (ts_nanoseconds),
    .sof_pulse       (sof_pulse),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_id          (out_id),
    .out_seconds     (out_seconds),
    .out_nanoseconds (out_nanoseconds),
    .pending         (pending),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int s, input int ns);
    exp_t e;
    e.id = IW'(id);
    e.s  = 32'(s);
    e.ns = 32'(ns);
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [NUM_REQ-1:0] mask, input int s, input int ns);
    ts_seconds     = 32'(s);
    ts_nanoseconds = 32'(ns);
    sof_pulse      = mask;
    tick();
    sof_pulse      = '0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    sof_pulse = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    chk({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  // Handshake completes at the next rising edge; score it here.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_id", 64'(out_id), 64'(e.id));
        chk("out_seconds", 64'(out_seconds), 64'(e.s));
        chk("out_nanoseconds", 64'(out_nanoseconds), 64'(e.ns));
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    ts_seconds     = '0;
    ts_nanoseconds = '0;
    sof_pulse      = '0;
    out_ready      = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_id", 64'(out_id), 64'd0);
    chk("rst_sec", 64'(out_seconds), 64'd0);
    chk("rst_ns", 64'(out_nanoseconds), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // Single capture with latency check
    out_ready = 1'b1;
    push(1, 5, 40);
    pulse(4'b0010, 5, 40);
    chk("single_pend_t1", 64'(pending), 64'b0010);
    chk("single_valid_t1", 64'(out_valid), 64'd0);
    tick();
    chk("single_valid_t2", 64'(out_valid), 64'd1);
    chk("single_id_t2", 64'(out_id), 64'd1);
    tick();
    chk("single_pend_done", 64'(pending), 64'd0);
    wait_drain("single");

    // Simultaneous capture
    do_reset();
    out_ready = 1'b1;
    push(0, 7, 100);
    push(2, 7, 100);
    pulse(4'b0101, 7, 100);
    wait_drain("simul");
    chk("simul_drop", 64'(drop_count), 64'd0);

    // Backpressure: outputs frozen while out_ready is low
    do_reset();
    push(2, 9, 300);
    pulse(4'b0100, 9, 300);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_id", 64'(out_id), 64'd2);
      chk("bp_sec", 64'(out_seconds), 64'd9);
      chk("bp_ns", 64'(out_nanoseconds), 64'd300);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp");

    // Overflow: port 0 holds the output register, port 3 overflows, then 1,2,3 together
    do_reset();
    pulse(4'b0001, 0, 500);
    pulse(4'b1000, 1, 20);
    pulse(4'b1000, 1, 60);
`ifdef TS_SNAPSHOT_DROP_CNT_EN
    chk("ovf_drop1", 64'(drop_count), 64'd1);
`else
    chk("ovf_drop1", 64'(drop_count), 64'd0);
`endif
    pulse(4'b0110, 2, 80);
    pulse(4'b1110, 2, 90);
`ifdef TS_SNAPSHOT_DROP_CNT_EN
    chk("ovf_drop4", 64'(drop_count), 64'd4);
`else
    chk("ovf_drop4", 64'(drop_count), 64'd0);
`endif
    chk("ovf_pending", 64'(pending), 64'b1110);
    push(0, 0, 500);
    push(1, 2, 80);
    push(2, 2, 80);
    push(3, 1, 20);
    out_ready = 1'b1;
    wait_drain("ovf");

    // Fairness: every port pulses every cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(i % 4, 3, 20);
    ts_seconds     = 32'd3;
    ts_nanoseconds = 32'd20;
    sof_pulse      = 4'b1111;
    for (int i = 0; i < 9; i++) tick();
    sof_pulse = '0;
    wait_drain("fair");
    chk("fair_pending", 64'(pending), 64'd0);

    // Reset mid-stream
    do_reset();
    pulse(4'b1111, 4, 40);
    tick();
    chk("mid_pending", 64'(pending), 64'b1110);
    chk("mid_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb.delete();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pending", 64'(pending), 64'd0);
    out_ready = 1'b1;
    push(1, 6, 60);
    push(2, 6, 60);
    pulse(4'b0110, 6, 60);
    wait_drain("mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
